// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction slice.
//   state_t : resolver FSM states
//   entry_t : in-flight prediction record at the default 32-bit PC width
//   PC_STEP : fall-through increment for a not-taken branch
package bp_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } entry_t;

endpackage

// File: rtl/bp_fifo.sv
// Parameterised circular FIFO with wrap-around pointers and an entry count.
//   clock, reset         : rising-edge clock, async active-low reset
//   push / wdata         : write one entry (ignored when full)
//   pop / rdata          : drop the oldest entry (ignored when empty); rdata shows it
//   clear                : empty the FIFO, takes priority over push/pop
//   full, empty, count   : occupancy status
module bp_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// In-order branch resolution unit. Queues issued predictions, compares the
// oldest against the execute outcome, drives the predictor table update,
// flushes and redirects fetch on a mispredict, and keeps hit/miss counts.
//   clock, reset                         : rising-edge clock, async active-low reset
//   pred_valid/pc/taken/target, pred_ready : prediction enqueue handshake
//   res_valid/taken, res_ready           : outcome handshake for the oldest entry
//   fix_valid/pc/result                  : registered table-update strobe
//   flush, redirect_pc                   : registered one-cycle flush and fetch target
//   hit_count, miss_count                : saturating statistics
//   occupancy                            : queued entries
module branch_resolver
  import bp_pkg::*;
#(
  parameter int unsigned n            = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [n-1:0]             pred_pc,
  input  logic                     pred_taken,
  input  logic [n-1:0]             pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     fix_valid,
  output logic [n-1:0]             fix_pc,
  output logic                     fix_result,
  output logic                     flush,
  output logic [n-1:0]             redirect_pc,
  output logic [n-1:0]             hit_count,
  output logic [n-1:0]             miss_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES) + 1;

  typedef struct packed {
    logic [n-1:0] pc;
    logic         taken;
    logic [n-1:0] target;
  } slot_t;

  slot_t           wr_slot;
  slot_t           head;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;
  logic            hit;
  logic            miss;
  logic [n-1:0]    redirect_next;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   flush_cnt;
  logic [CW-1:0]   flush_cnt_next;

  assign wr_slot    = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  assign pred_ready = (state == RUN) && !full;
  assign res_ready  = (state == RUN) && !empty;
  assign enq        = pred_valid && pred_ready;
  assign deq        = res_valid && res_ready;
  assign hit        = deq && (res_taken == head.taken);
  assign miss       = deq && (res_taken != head.taken);

  assign redirect_next = res_taken ? head.target : head.pc + n'(PC_STEP);

  // A mispredict clears the queue, which also drops any same-cycle enqueue.
  bp_fifo #(
    .WIDTH($bits(slot_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (enq && !miss),
    .pop   (hit),
    .clear (miss),
    .wdata (wr_slot),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      RUN: begin
        if (miss) begin
          state_next     = FLUSH;
          flush_cnt_next = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) state_next = RUN;
        else                 flush_cnt_next = flush_cnt - CW'(1);
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fix_valid   <= 1'b0;
      fix_pc      <= '0;
      fix_result  <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      fix_valid <= deq;
      flush     <= miss;
      if (deq) begin
        fix_pc     <= head.pc;
        fix_result <= res_taken;
      end
      if (miss) redirect_pc <= redirect_next;
      if (hit && (hit_count != '1))   hit_count  <= hit_count + n'(1);
      if (miss && (miss_count != '1)) miss_count <= miss_count + n'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
  import bp_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        pred_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        res_ready;
  logic        fix_valid;
  logic [31:0] fix_pc;
  logic        fix_result;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [3:0]  occupancy;

  branch_resolver #(
    .n(32),
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_ready   (res_ready),
    .fix_valid   (fix_valid),
    .fix_pc      (fix_pc),
    .fix_result  (fix_result),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of outstanding predictions plus expected outputs.
  entry_t      mq[$];
  logic [31:0] m_hit, m_miss, m_fix_pc, m_redir;
  logic        m_fix_valid, m_fix_res, m_flush;
  int          m_flush_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hit = '0; m_miss = '0; m_fix_pc = '0; m_redir = '0;
    m_fix_valid = 1'b0; m_fix_res = 1'b0; m_flush = 1'b0;
    m_flush_left = 0;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                       input logic [31:0] tgt, input logic rv, input logic rt);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = tgt;
    res_valid = rv; res_taken = rt;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit     exp_pr, exp_rr, enq, deq;
    entry_t e, h;
    exp_pr = (m_flush_left == 0) && (mq.size() < DEPTH);
    exp_rr = (m_flush_left == 0) && (mq.size() > 0);
    check("pred_ready", 64'(pred_ready), 64'(exp_pr));
    check("res_ready", 64'(res_ready), 64'(exp_rr));
    check("occupancy_pre", 64'(occupancy), 64'(mq.size()));
    enq = pred_valid && exp_pr;
    deq = res_valid && exp_rr;
    e.pc = pred_pc; e.taken = pred_taken; e.target = pred_target;
    if (m_flush_left > 0) m_flush_left--;
    m_fix_valid = deq;
    m_flush = 1'b0;
    if (deq) begin
      h = mq[0];
      m_fix_pc = h.pc;
      m_fix_res = res_taken;
      if (res_taken == h.taken) begin
        if (m_hit != 32'hFFFF_FFFF) m_hit++;
        void'(mq.pop_front());
        if (enq) mq.push_back(e);
      end else begin
        if (m_miss != 32'hFFFF_FFFF) m_miss++;
        mq.delete();
        m_flush = 1'b1;
        m_redir = res_taken ? h.target : h.pc + 32'd4;
        m_flush_left = FC;
      end
    end else if (enq) begin
      mq.push_back(e);
    end
    @(posedge clock);
    #1;
    check("fix_valid", 64'(fix_valid), 64'(m_fix_valid));
    check("fix_pc", 64'(fix_pc), 64'(m_fix_pc));
    check("fix_result", 64'(fix_result), 64'(m_fix_res));
    check("flush", 64'(flush), 64'(m_flush));
    check("redirect_pc", 64'(redirect_pc), 64'(m_redir));
    check("hit_count", 64'(hit_count), 64'(m_hit));
    check("miss_count", 64'(miss_count), 64'(m_miss));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive(0, '0, 0, '0, 0, 0);
      step();
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released at a falling edge.
  task automatic do_reset();
    drive(0, '0, 0, '0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_hit", 64'(hit_count), 64'd0);
    check("rst_miss", 64'(miss_count), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_fix_valid", 64'(fix_valid), 64'd0);
    check("rst_res_ready", 64'(res_ready), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_pred_ready", 64'(pred_ready), 64'd1);
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();

    // In-order hits
    drive(1, 32'h100, 1, 32'h140, 0, 0); step();
    drive(1, 32'h200, 0, 32'h240, 0, 0); step();
    drive(0, '0, 0, '0, 1, 1); step();
    check("hit1_fix_pc", 64'(fix_pc), 64'h100);
    check("hit1_fix_res", 64'(fix_result), 64'd1);
    drive(0, '0, 0, '0, 1, 0); step();
    check("hit2_fix_pc", 64'(fix_pc), 64'h200);
    check("hit2_count", 64'(hit_count), 64'd2);
    check("hit2_noflush", 64'(flush), 64'd0);

    // Taken mispredict with two younger entries; pred_valid held through FLUSH
    drive(1, 32'h300, 0, 32'h380, 0, 0); step();
    drive(1, 32'h304, 1, 32'h500, 0, 0); step();
    drive(1, 32'h500, 0, 32'h600, 0, 0); step();
    drive(1, 32'h700, 0, 32'h704, 1, 1); step();
    check("tmiss_flush", 64'(flush), 64'd1);
    check("tmiss_redirect", 64'(redirect_pc), 64'h380);
    check("tmiss_occ", 64'(occupancy), 64'd0);
    check("tmiss_count", 64'(miss_count), 64'd1);
    drive(1, 32'h800, 0, 32'h804, 0, 0); step();
    drive(1, 32'h800, 0, 32'h804, 0, 0); step();
    drive(1, 32'h800, 0, 32'h804, 0, 0); step();
    idle(1);

    // Not-taken mispredict at the top of the address space
    drive(0, '0, 0, '0, 1, 0); step();
    drive(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0); step();
    drive(0, '0, 0, '0, 1, 0); step();
    check("wrap_redirect", 64'(redirect_pc), 64'h0);
    idle(3);

    // Full queue, ignored 9th push, simultaneous hit + push when full
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h1000 + 32'(i) * 32'h10, 1, 32'h2000, 0, 0); step();
    end
    check("full_pred_ready", 64'(pred_ready), 64'd0);
    drive(1, 32'hDEAD_0000, 1, 32'h0, 0, 0); step();
    drive(1, 32'hBEEF_0000, 0, 32'h0, 1, 1); step();
    check("full_hit_occ", 64'(occupancy), 64'd7);
    drive(1, 32'hBEEF_0000, 0, 32'h0, 0, 0); step();
    check("full_reenq_occ", 64'(occupancy), 64'd8);

    // Saturation of hit_count
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    m_hit = 32'hFFFF_FFFF;
    drive(0, '0, 0, '0, 1, 1); step();
    check("sat_hit", 64'(hit_count), 64'hFFFF_FFFF);

    // Reset with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h40 * 32'(i + 1), 0, 32'h9000, 0, 0); step();
    end
    check("five_queued", 64'(occupancy), 64'd5);
    do_reset();

    // Reset while in FLUSH
    drive(1, 32'h3000, 1, 32'h3400, 0, 0); step();
    drive(1, 32'h3004, 1, 32'h3400, 1, 0); step();
    check("pre_rst_flush", 64'(flush), 64'd1);
    do_reset();
    check("rst_flush_exit_pr", 64'(pred_ready), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] pc, tgt;
      pv  = ($urandom % 10) < 6;
      pc  = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      pt  = 1'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      rv  = ($urandom % 10) < 6;
      if (mq.size() > 0) rt = (($urandom % 5) == 0) ? !mq[0].taken : mq[0].taken;
      else               rt = 1'($urandom);
      drive(pv, pc, pt, tgt, rv, rt);
      step();
      if (($urandom % 500) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
